// File: rtl/keccak_pkg.sv
// Shared types and constants for the keccak input-side packer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package keccak_pkg;

    localparam int KECCAK_WORD_W     = 64;
    localparam int KECCAK_WORD_BYTES = 8;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        SEND = 2'd1,
        LAST = 2'd2,
        DONE = 2'd3
    } state_t;

    // MSB index of byte lane idx inside a word; lane 0 sits in bits [63:56].
    function automatic logic [5:0] lane_msb(input logic [2:0] idx);
        lane_msb = {3'd7 - idx, 3'b111};
    endfunction

endpackage

// File: rtl/keccak_byte_packer.sv
// Packs a byte stream into 64-bit words (first byte in [63:56]) for the keccak core.
// Latency: word presented the cycle after its 8th byte, s_last byte or s_empty pulse.
// Backpressure: holds the word stable while k_buffer_full; s_ready low outside FILL.
module keccak_byte_packer
    import keccak_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_byte,
    input  logic        s_valid,
    input  logic        s_last,
    input  logic        s_empty,
    output logic        s_ready,
    output logic [63:0] k_in,
    output logic        k_in_ready,
    output logic        k_is_last,
    output logic [2:0]  k_byte_num,
    input  logic        k_buffer_full,
    output logic        msg_done
);

    state_t      state, state_nxt;
    logic [63:0] acc, acc_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        pend_last, pend_last_nxt;
    logic [2:0]  byte_num_nxt;
    logic        k_xfer;
    logic        empty_req;

    // s_ready depends on state alone, so the core's buffer_full never reaches it.
    assign s_ready   = (state == FILL);
    assign k_xfer    = k_in_ready & ~k_buffer_full;
    assign empty_req = s_empty & (cnt == 4'd0);
    // acc is a register and is only cleared after a transfer, so it doubles as the word output.
    assign k_in      = acc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and datapath update; s_empty beats a coincident byte at cnt == 0.
    always_comb begin
        state_nxt     = state;
        acc_nxt       = acc;
        cnt_nxt       = cnt;
        pend_last_nxt = pend_last;
        byte_num_nxt  = k_byte_num;
        case (state)
            FILL: begin
                if (empty_req) begin
                    acc_nxt      = '0;
                    byte_num_nxt = 3'd0;
                    state_nxt    = LAST;
                end else if (s_valid) begin
                    acc_nxt[lane_msb(cnt[2:0]) -: 8] = s_byte;
                    cnt_nxt = cnt + 4'd1;
                    if (cnt_nxt == 4'(KECCAK_WORD_BYTES)) begin
                        // A full final word still owes an empty is_last word afterwards.
                        state_nxt     = SEND;
                        pend_last_nxt = s_last;
                    end else if (s_last) begin
                        state_nxt    = LAST;
                        byte_num_nxt = cnt_nxt[2:0];
                    end
                end
            end
            SEND: begin
                if (k_xfer) begin
                    acc_nxt = '0;
                    cnt_nxt = 4'd0;
                    if (pend_last) begin
                        state_nxt     = LAST;
                        byte_num_nxt  = 3'd0;
                        pend_last_nxt = 1'b0;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            LAST: begin
                if (k_xfer) begin
                    state_nxt = DONE;
                end
            end
            default: begin
                state_nxt = DONE;
            end
        endcase
    end

    // Datapath and registered core-side outputs, decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            cnt        <= 4'd0;
            pend_last  <= 1'b0;
            k_in_ready <= 1'b0;
            k_is_last  <= 1'b0;
            k_byte_num <= 3'd0;
            msg_done   <= 1'b0;
        end else begin
            acc        <= acc_nxt;
            cnt        <= cnt_nxt;
            pend_last  <= pend_last_nxt;
            k_in_ready <= (state_nxt == SEND) || (state_nxt == LAST);
            k_is_last  <= (state_nxt == LAST);
            k_byte_num <= byte_num_nxt;
            msg_done   <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_keccak_byte_packer.sv
// Directed bench for keccak_byte_packer.
// Latency: n/a.
// Backpressure: exercises k_buffer_full holds.
module tb_keccak_byte_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_last;
    logic        s_empty;
    logic        s_ready;
    logic [63:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [2:0]  k_byte_num;
    logic        k_buffer_full;
    logic        msg_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] xq[$];
    logic        lq[$];
    logic [2:0]  nq[$];

    keccak_byte_packer dut (
        .clk           (clk),
        .reset         (reset),
        .s_byte        (s_byte),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_empty       (s_empty),
        .s_ready       (s_ready),
        .k_in          (k_in),
        .k_in_ready    (k_in_ready),
        .k_is_last     (k_is_last),
        .k_byte_num    (k_byte_num),
        .k_buffer_full (k_buffer_full),
        .msg_done      (msg_done)
    );

    always #5 clk = ~clk;

    // Record every word the core would take at this edge.
    always @(posedge clk) begin
        if (!reset && k_in_ready && !k_buffer_full) begin
            xq.push_back(k_in);
            lq.push_back(k_is_last);
            nq.push_back(k_byte_num);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
        s_byte = 8'h00; k_buffer_full = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        xq.delete(); lq.delete(); nq.delete();
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b, input logic last);
        int t = 0;
        s_valid = 1'b1; s_byte = b; s_last = last;
        while (!s_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!s_ready) begin
            n_checks++; n_fail++;
            $display("FAIL send_byte_timeout byte=%h s_ready stayed 0", b);
        end
        @(negedge clk);
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_xfers(input int n);
        int t = 0;
        while (xq.size() < n && t < 50) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (xq.size() < n) begin
            n_fail++;
            $display("FAIL xfer_timeout got %0d words, need %0d", xq.size(), n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (k_in !== 64'h0)      begin n_fail++; $display("FAIL rst_k_in got %h exp 0", k_in); end
        n_checks++; if (k_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_k_in_ready got %b exp 0", k_in_ready); end
        n_checks++; if (k_is_last !== 1'b0)  begin n_fail++; $display("FAIL rst_k_is_last got %b exp 0", k_is_last); end
        n_checks++; if (k_byte_num !== 3'd0) begin n_fail++; $display("FAIL rst_k_byte_num got %0d exp 0", k_byte_num); end
        n_checks++; if (msg_done !== 1'b0)   begin n_fail++; $display("FAIL rst_msg_done got %b exp 0", msg_done); end
        n_checks++; if (s_ready !== 1'b1)    begin n_fail++; $display("FAIL rst_s_ready got %b exp 1", s_ready); end
    endtask

    task automatic test_short();
        do_reset();
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        n_checks++; if (k_in_ready !== 1'b1) begin n_fail++; $display("FAIL short_latency k_in_ready got %b exp 1", k_in_ready); end
        n_checks++; if (s_ready !== 1'b0)    begin n_fail++; $display("FAIL short_s_ready got %b exp 0", s_ready); end
        wait_xfers(1);
        if (xq.size() >= 1) begin
            n_checks++; if (xq[0] !== 64'h6162630000000000) begin n_fail++; $display("FAIL short_word got %h exp 6162630000000000", xq[0]); end
            n_checks++; if (lq[0] !== 1'b1) begin n_fail++; $display("FAIL short_is_last got %b exp 1", lq[0]); end
            n_checks++; if (nq[0] !== 3'd3) begin n_fail++; $display("FAIL short_byte_num got %0d exp 3", nq[0]); end
        end
        n_checks++; if (msg_done !== 1'b1)   begin n_fail++; $display("FAIL short_msg_done got %b exp 1", msg_done); end
        n_checks++; if (k_in_ready !== 1'b0) begin n_fail++; $display("FAIL short_done_in_ready got %b exp 0", k_in_ready); end
    endtask

    task automatic test_exact8();
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), (i == 8));
        wait_xfers(2);
        if (xq.size() >= 2) begin
            n_checks++; if (xq[0] !== 64'h0102030405060708) begin n_fail++; $display("FAIL exact8_w0 got %h exp 0102030405060708", xq[0]); end
            n_checks++; if (lq[0] !== 1'b0) begin n_fail++; $display("FAIL exact8_w0_last got %b exp 0", lq[0]); end
            n_checks++; if (xq[1] !== 64'h0) begin n_fail++; $display("FAIL exact8_w1 got %h exp 0", xq[1]); end
            n_checks++; if (lq[1] !== 1'b1) begin n_fail++; $display("FAIL exact8_w1_last got %b exp 1", lq[1]); end
            n_checks++; if (nq[1] !== 3'd0) begin n_fail++; $display("FAIL exact8_w1_num got %0d exp 0", nq[1]); end
        end
        n_checks++; if (msg_done !== 1'b1) begin n_fail++; $display("FAIL exact8_msg_done got %b exp 1", msg_done); end
        repeat (4) @(negedge clk);
        n_checks++; if (xq.size() !== 2) begin n_fail++; $display("FAIL exact8_count got %0d exp 2", xq.size()); end
    endtask

    task automatic test_two_word();
        do_reset();
        for (int i = 0; i < 10; i++) send_byte(8'(8'h10 + i), (i == 9));
        wait_xfers(2);
        if (xq.size() >= 2) begin
            n_checks++; if (xq[0] !== 64'h1011121314151617) begin n_fail++; $display("FAIL two_w0 got %h exp 1011121314151617", xq[0]); end
            n_checks++; if (lq[0] !== 1'b0) begin n_fail++; $display("FAIL two_w0_last got %b exp 0", lq[0]); end
            n_checks++; if (xq[1] !== 64'h1819000000000000) begin n_fail++; $display("FAIL two_w1 got %h exp 1819000000000000", xq[1]); end
            n_checks++; if (lq[1] !== 1'b1) begin n_fail++; $display("FAIL two_w1_last got %b exp 1", lq[1]); end
            n_checks++; if (nq[1] !== 3'd2) begin n_fail++; $display("FAIL two_w1_num got %0d exp 2", nq[1]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        k_buffer_full = 1'b1;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hA0 + i), 1'b0);
        // Offer a byte the packer must not take while the word is held.
        s_valid = 1'b1; s_byte = 8'hEE; s_last = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (k_in !== 64'hA0A1A2A3A4A5A6A7) begin n_fail++; $display("FAIL bp_k_in cyc %0d got %h exp a0a1a2a3a4a5a6a7", c, k_in); end
            n_checks++; if (k_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready cyc %0d got %b exp 1", c, k_in_ready); end
            n_checks++; if (k_is_last !== 1'b0)  begin n_fail++; $display("FAIL bp_is_last cyc %0d got %b exp 0", c, k_is_last); end
            n_checks++; if (s_ready !== 1'b0)    begin n_fail++; $display("FAIL bp_s_ready cyc %0d got %b exp 0", c, s_ready); end
            @(negedge clk);
        end
        n_checks++; if (xq.size() !== 0) begin n_fail++; $display("FAIL bp_early_xfer got %0d words exp 0", xq.size()); end
        s_valid = 1'b0; s_last = 1'b0;
        k_buffer_full = 1'b0;
        @(negedge clk);
        n_checks++; if (xq.size() !== 1) begin n_fail++; $display("FAIL bp_release got %0d words exp 1", xq.size()); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL bp_resume_s_ready got %b exp 1", s_ready); end
        send_byte(8'hB0, 1'b1);
        wait_xfers(2);
        if (xq.size() >= 2) begin
            n_checks++; if (xq[0] !== 64'hA0A1A2A3A4A5A6A7) begin n_fail++; $display("FAIL bp_w0 got %h exp a0a1a2a3a4a5a6a7", xq[0]); end
            n_checks++; if (xq[1] !== 64'hB000000000000000) begin n_fail++; $display("FAIL bp_w1 got %h exp b000000000000000", xq[1]); end
            n_checks++; if (nq[1] !== 3'd1) begin n_fail++; $display("FAIL bp_w1_num got %0d exp 1", nq[1]); end
        end
    endtask

    task automatic test_empty();
        do_reset();
        s_empty = 1'b1; s_valid = 1'b1; s_byte = 8'h55;
        @(negedge clk);
        s_empty = 1'b0;
        wait_xfers(1);
        if (xq.size() >= 1) begin
            n_checks++; if (xq[0] !== 64'h0) begin n_fail++; $display("FAIL empty_word got %h exp 0", xq[0]); end
            n_checks++; if (lq[0] !== 1'b1) begin n_fail++; $display("FAIL empty_is_last got %b exp 1", lq[0]); end
            n_checks++; if (nq[0] !== 3'd0) begin n_fail++; $display("FAIL empty_byte_num got %0d exp 0", nq[0]); end
        end
        repeat (5) @(negedge clk);
        n_checks++; if (s_ready !== 1'b0)  begin n_fail++; $display("FAIL empty_s_ready got %b exp 0", s_ready); end
        n_checks++; if (msg_done !== 1'b1) begin n_fail++; $display("FAIL empty_msg_done got %b exp 1", msg_done); end
        n_checks++; if (xq.size() !== 1)   begin n_fail++; $display("FAIL empty_count got %0d exp 1", xq.size()); end
        s_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b0);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (k_in !== 64'h0)      begin n_fail++; $display("FAIL midrst_k_in got %h exp 0", k_in); end
        n_checks++; if (k_in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready got %b exp 0", k_in_ready); end
        n_checks++; if (msg_done !== 1'b0)   begin n_fail++; $display("FAIL midrst_msg_done got %b exp 0", msg_done); end
        n_checks++; if (s_ready !== 1'b1)    begin n_fail++; $display("FAIL midrst_s_ready got %b exp 1", s_ready); end
        reset = 1'b0;
        xq.delete(); lq.delete(); nq.delete();
        send_byte(8'hAA, 1'b1);
        wait_xfers(1);
        if (xq.size() >= 1) begin
            n_checks++; if (xq[0] !== 64'hAA00000000000000) begin n_fail++; $display("FAIL midrst_word got %h exp aa00000000000000", xq[0]); end
            n_checks++; if (nq[0] !== 3'd1) begin n_fail++; $display("FAIL midrst_byte_num got %0d exp 1", nq[0]); end
        end
    endtask

    initial begin
        reset = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0;
        s_byte = 8'h00; k_buffer_full = 1'b0;
        test_reset();
        test_short();
        test_exact8();
        test_two_word();
        test_backpressure();
        test_empty();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keccak_byte_packer.md
# keccak_byte_packer

Upstream feeder for the `keccak` hash core. Accepts a message as a stream of bytes over a valid/ready handshake and packs them into 64-bit words, first byte in bits [63:56]. Presents each word on the core's `in`/`in_ready`/`is_last`/`byte_num` input port and honours its `buffer_full` back-pressure. Closes every message with exactly one `is_last` word. Handles one message per reset, matching the core's single-message behaviour.

## Interface
- No parameters. Word width is 64 and bytes per word is 8, both fixed.
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `s_byte`  in  8  message byte.
- `s_valid`  in  1  `s_byte` is valid.
- `s_last`  in  1  qualifies `s_valid`; this byte ends the message.
- `s_empty`  in  1  single-cycle request for a zero-length message. Honoured only in FILL with count 0; ignored otherwise.
- `s_ready`  out  1  the packer accepts a byte this cycle.
- `k_in`  out  64  word to the core's `in`.
- `k_in_ready`  out  1  drives the core's `in_ready`.
- `k_is_last`  out  1  drives the core's `is_last`.
- `k_byte_num`  out  3  drives the core's `byte_num`. Meaningful only when `k_is_last` is 1.
- `k_buffer_full`  in  1  the core's `buffer_full`.
- `msg_done`  out  1  the last word has been transferred. Sticky until reset.

## Operation
- Registers:
  - `acc[63:0]`: word being assembled.
  - `cnt[3:0]`: bytes held, 0..8.
  - `state`.
  - `pend_last`: a final word is still owed.
- Byte accept: `s_valid & s_ready`. Word transfer: `k_in_ready & ~k_buffer_full`, sampled at the clock edge.
- States and transitions:
  - **FILL**
    - `s_ready` = 1.
    - An accepted byte is written to `acc[63-8*cnt -: 8]` and `cnt` increments.
    - If `cnt+1 == 8` and `s_last` = 0: go to SEND.
    - If `cnt+1 == 8` and `s_last` = 1: go to SEND and set `pend_last`.
    - If `cnt+1 < 8` and `s_last` = 1: go to LAST with `k_byte_num` = `cnt+1`.
    - `s_empty` with `cnt` = 0: go to LAST with `acc` = 0 and `k_byte_num` = 0.
  - **SEND**
    - `s_ready` = 0; `k_in_ready` = 1; `k_is_last` = 0; `k_in` = `acc`.
    - On transfer: `acc` ← 0 and `cnt` ← 0.
    - Then, if `pend_last` = 1: go to LAST with `k_byte_num` = 0 (this clears `pend_last`). Otherwise go to FILL.
  - **LAST**
    - `s_ready` = 0; `k_in_ready` = 1; `k_is_last` = 1.
    - On transfer: go to DONE.
  - **DONE**
    - `s_ready` = 0; `k_in_ready` = 0; `msg_done` = 1.
    - Exit only via reset.
- Byte lanes of the final word that hold no message bytes are 0.
- `k_is_last` is never 1 while `k_in_ready` is 0.
- A message whose length is a multiple of 8 ends with an extra empty word: `k_is_last` = 1, `k_byte_num` = 0.
- `s_byte` and `s_last` are ignored when `s_ready` is 0. An `s_valid` in SEND, LAST or DONE is not consumed.
- If `s_empty` and `s_valid` are both high in FILL with `cnt` = 0, `s_empty` wins and the byte is not consumed.

## Timing
- Reset values:
  - `state` = FILL.
  - `acc` = 0, `cnt` = 0, `pend_last` = 0.
  - `k_in` = 0, `k_in_ready` = 0, `k_is_last` = 0, `k_byte_num` = 0, `msg_done` = 0.
  - `s_ready` = 1 from the first cycle after reset.
- All `k_*` outputs and `msg_done` are registered. `s_ready` is decoded from `state` only, with no combinational path from `k_buffer_full`.
- Latency: `k_in_ready` rises on the cycle after the 8th byte, the `s_last` byte, or the `s_empty` cycle.
- The earliest word transfer is that same cycle. FILL resumes on the cycle after the transfer.
- Peak throughput is 8 bytes per 9 cycles.
- While `k_buffer_full` = 1, `k_in`, `k_is_last` and `k_byte_num` stay stable and `k_in_ready` stays high, for any duration.
- `msg_done` rises on the cycle after the LAST transfer.
- Reset mid-operation, in any state, discards partial data and returns every output to its reset value on the next cycle.

## Structure
- Package `keccak_pkg`: state enum (FILL, SEND, LAST, DONE), `KECCAK_WORD_W` = 64, `KECCAK_WORD_BYTES` = 8.
- Single flat module; no sub-module. Byte-lane insertion is an indexed part-select into `acc`.

## Test plan
- **Short message:** 3 bytes 0x61 0x62 0x63, last on 0x63, `k_buffer_full` = 0 → one transfer: `k_in` = 0x6162630000000000, `k_is_last` = 1, `k_byte_num` = 3; then `msg_done` = 1.
- **Exact 8 bytes:** 0x01..0x08, last on 0x08 → two transfers:
  - 0x0102030405060708 with `k_is_last` = 0;
  - then 0x0 with `k_is_last` = 1 and `k_byte_num` = 0.
- **Two-word message:** 10 bytes 0x10..0x19 → two transfers:
  - 0x1011121314151617 with `k_is_last` = 0;
  - then 0x1819000000000000 with `k_is_last` = 1 and `k_byte_num` = 2.
- **Back-pressure:** hold `k_buffer_full` = 1 for 5 cycles while a word is presented → `k_*` outputs stable, `s_ready` = 0, no bytes lost; the transfer completes on the first cycle with `k_buffer_full` = 0.
- **Empty message:** `s_empty` pulse after reset → one transfer with `k_in` = 0, `k_is_last` = 1, `k_byte_num` = 0. A later `s_valid` is never accepted.
- **Reset mid-fill:** reset after 5 of 8 bytes → all outputs at reset values. Then send 0xAA with last → `k_in` = 0xAA00000000000000, `k_byte_num` = 1.
